// File: rtl/serial_subtractor_n_pkg.sv
// Shared definitions for the bit-serial arithmetic units:
// FSM state encoding and the bit-counter width helper.
package serial_subtractor_n_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Counter must hold 0..n without wrapping.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/serial_subtractor_n_full_subtractor.sv
// 1-bit full subtractor: d = x - y - br, bo = borrow out.
// Ports: x, y, br in; d, bo out.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic br,
  output logic d,
  output logic bo
);

  assign d  = x ^ y ^ br;
  assign bo = (~x & y) | (~(x ^ y) & br);

endmodule

// File: rtl/serial_subtractor_n.sv
// Bit-serial N-bit subtractor: diff = a - b - bin, LSB first, N cycles.
// Ports: clk, rst_n, start, a, b, bin in; diff, bout, busy, done out.
module serial_subtractor_n
  import serial_subtractor_n_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         bin,
  output logic [N-1:0] diff,
  output logic         bout,
  output logic         busy,
  output logic         done
);

  localparam int CW = cnt_width(N);

  state_e        state_q;
  logic [N-1:0]  a_q;
  logic [N-1:0]  b_q;
  logic [N-1:0]  res_q;
  logic [N-1:0]  res_d;
  logic [N-1:0]  diff_q;
  logic [CW-1:0] cnt_q;
  logic          br_q;
  logic          bout_q;
  logic          busy_q;
  logic          done_q;
  logic          d_bit;
  logic          bo_bit;
  logic          last;

  full_subtractor u_fs (
    .x  (a_q[0]),
    .y  (b_q[0]),
    .br (br_q),
    .d  (d_bit),
    .bo (bo_bit)
  );

  // New result bit enters from the MSB side.
  always_comb begin
    res_d        = res_q >> 1;
    res_d[N-1]   = d_bit;
  end

  assign last = (cnt_q == CW'(N - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      diff_q  <= '0;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      bout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q <= SHIFT;
            a_q     <= a;
            b_q     <= b;
            br_q    <= bin;
            res_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        SHIFT: begin
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          br_q  <= bo_bit;
          res_q <= res_d;
          cnt_q <= cnt_q + CW'(1);
          if (last) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            diff_q  <= res_d;
            bout_q  <= bo_bit;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign diff = diff_q;
  assign bout = bout_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_serial_subtractor_n.sv
// Self-checking bench for serial_subtractor_n at N=4, N=1 and N=8.
// Expected values come from plain integer arithmetic.
module tb_serial_subtractor_n;

  logic       clk;
  logic       rst_n;
  logic       st     [3];
  logic [7:0] a_v    [3];
  logic [7:0] b_v    [3];
  logic       bin_v  [3];
  logic [7:0] diff_v [3];
  logic       bout_v [3];
  logic       busy_v [3];
  logic       done_v [3];
  logic [3:0] d4;
  logic [0:0] d1;
  logic [7:0] d8;

  int tests;
  int fails;
  int wid [3];

  serial_subtractor_n #(.N(4)) u_n4 (
    .clk(clk), .rst_n(rst_n), .start(st[0]),
    .a(a_v[0][3:0]), .b(b_v[0][3:0]), .bin(bin_v[0]),
    .diff(d4), .bout(bout_v[0]), .busy(busy_v[0]), .done(done_v[0])
  );

  serial_subtractor_n #(.N(1)) u_n1 (
    .clk(clk), .rst_n(rst_n), .start(st[1]),
    .a(a_v[1][0:0]), .b(b_v[1][0:0]), .bin(bin_v[1]),
    .diff(d1), .bout(bout_v[1]), .busy(busy_v[1]), .done(done_v[1])
  );

  serial_subtractor_n #(.N(8)) u_n8 (
    .clk(clk), .rst_n(rst_n), .start(st[2]),
    .a(a_v[2]), .b(b_v[2]), .bin(bin_v[2]),
    .diff(d8), .bout(bout_v[2]), .busy(busy_v[2]), .done(done_v[2])
  );

  assign diff_v[0] = {4'b0, d4};
  assign diff_v[1] = {7'b0, d1};
  assign diff_v[2] = d8;

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       bi;
    logic [3:0] ed;
    logic       eb;
  } vec_t;

  // Reference: {bout, diff} from integer arithmetic on w-bit operands.
  function automatic logic [8:0] model(input int w, input int a,
                                       input int b, input int bi);
    int m;
    int r;
    logic [8:0] o;
    m = (1 << w) - 1;
    a = a & m;
    b = b & m;
    r = a - b - bi;
    o[7:0] = 8'(r & m);
    o[8]   = (a < b + bi);
    return o;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  // One complete operation on instance k; returns result, edges to
  // done (counted after the accept edge) and number of busy cycles.
  task automatic op(input int k, input logic [7:0] a, input logic [7:0] b,
                    input logic bi, output logic [7:0] d,
                    output logic bo, output int lat, output int bc);
    @(negedge clk);
    a_v[k] = a;
    b_v[k] = b;
    bin_v[k] = bi;
    st[k] = 1'b1;
    @(posedge clk);
    #1;
    st[k] = 1'b0;
    lat = 0;
    bc = 0;
    while (!done_v[k] && lat < 30) begin
      if (busy_v[k]) bc++;
      @(posedge clk);
      #1;
      lat++;
    end
    d  = diff_v[k];
    bo = bout_v[k];
  endtask

  vec_t       tbl [5];
  logic [7:0] rd;
  logic       rb;
  int         lat;
  int         bc;
  logic [8:0] e;
  logic [7:0] opa [5];
  logic [7:0] opb [5];
  logic       opi [5];
  logic [7:0] prev;
  int         dn;
  int         stable_bad;
  int         cnt;

  initial begin
    tests = 0;
    fails = 0;
    wid[0] = 4;
    wid[1] = 1;
    wid[2] = 8;
    clk = 1'b0;
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      st[k] = 1'b0;
      a_v[k] = '0;
      b_v[k] = '0;
      bin_v[k] = 1'b0;
    end

    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("reset_out_n%0d", wid[k]),
          {diff_v[k], bout_v[k], busy_v[k], done_v[k]}, 32'd0);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    tbl[0] = '{4'b0011, 4'b0000, 1'b0, 4'b0011, 1'b0};
    tbl[1] = '{4'b0000, 4'b0011, 1'b0, 4'b1101, 1'b1};
    tbl[2] = '{4'b1010, 4'b1010, 1'b1, 4'b1111, 1'b1};
    tbl[3] = '{4'b0000, 4'b0000, 1'b1, 4'b1111, 1'b1};
    tbl[4] = '{4'b1111, 4'b1111, 1'b0, 4'b0000, 1'b0};
    for (int i = 0; i < 5; i++) begin
      op(0, {4'b0, tbl[i].a}, {4'b0, tbl[i].b}, tbl[i].bi,
         rd, rb, lat, bc);
      chk($sformatf("tbl%0d_res", i), {rd, rb}, {4'b0, tbl[i].ed, tbl[i].eb});
      chk($sformatf("tbl%0d_lat", i), lat, 4);
      chk($sformatf("tbl%0d_busy", i), bc, 4);
    end
    @(posedge clk);
    #1;
    chk("done_one_cycle", {done_v[0], busy_v[0]}, 0);

    // Start pulses and operand changes while shifting are ignored.
    @(negedge clk);
    a_v[0] = 8'b1010;
    b_v[0] = 8'b0101;
    bin_v[0] = 1'b0;
    st[0] = 1'b1;
    @(posedge clk);
    #1;
    st[0] = 1'b0;
    dn = 0;
    rd = '0;
    rb = 1'b1;
    for (int ed = 1; ed <= 7; ed++) begin
      @(negedge clk);
      a_v[0] = 8'($urandom);
      b_v[0] = 8'($urandom);
      st[0] = (ed == 2 || ed == 3);
      if (ed == 2 || ed == 3) begin
        a_v[0] = 8'b1111;
        b_v[0] = 8'b0001;
      end
      @(posedge clk);
      #1;
      if (done_v[0]) begin
        dn++;
        rd = diff_v[0];
        rb = bout_v[0];
      end
    end
    st[0] = 1'b0;
    chk("ign_done_cnt", dn, 1);
    chk("ign_res", {rd, rb}, {8'b0101, 1'b0});
    chk("ign_idle", busy_v[0], 0);

    // Back-to-back with start held high.
    for (int j = 0; j < 5; j++) begin
      opa[j] = 8'($urandom_range(15));
      opb[j] = 8'($urandom_range(15));
      opi[j] = 1'($urandom_range(1));
    end
    @(negedge clk);
    a_v[0] = opa[0];
    b_v[0] = opb[0];
    bin_v[0] = opi[0];
    st[0] = 1'b1;
    @(posedge clk);
    #1;
    a_v[0] = opa[1];
    b_v[0] = opb[1];
    bin_v[0] = opi[1];
    prev = diff_v[0];
    stable_bad = 0;
    for (int j = 0; j < 4; j++) begin
      cnt = 0;
      while (!done_v[0] && cnt < 20) begin
        if (diff_v[0] !== prev) stable_bad++;
        @(posedge clk);
        #1;
        cnt++;
      end
      e = model(4, int'(opa[j]), int'(opb[j]), int'(opi[j]));
      chk($sformatf("b2b%0d_res", j), {diff_v[0], bout_v[0]},
          {e[7:0], e[8]});
      chk($sformatf("b2b%0d_gap", j), cnt, 4);
      prev = diff_v[0];
      if (j == 3) st[0] = 1'b0;
      @(posedge clk);
      #1;
      if (j < 3) begin
        a_v[0] = opa[j+2];
        b_v[0] = opb[j+2];
        bin_v[0] = opi[j+2];
      end
    end
    chk("b2b_stable", stable_bad, 0);

    // Asynchronous reset in the middle of an operation.
    op(0, 8'b0011, 8'b0000, 1'b0, rd, rb, lat, bc);
    chk("pre_rst_res", {rd, rb}, {8'b0011, 1'b0});
    @(negedge clk);
    a_v[0] = 8'b1111;
    b_v[0] = 8'b0001;
    st[0] = 1'b1;
    @(posedge clk);
    #1;
    st[0] = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async", {diff_v[0], bout_v[0], busy_v[0], done_v[0]}, 0);
    dn = 0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (done_v[0]) dn++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (done_v[0]) dn++;
    end
    chk("rst_no_done", dn, 0);
    op(0, 8'b0110, 8'b0010, 1'b0, rd, rb, lat, bc);
    chk("post_rst_res", {rd, rb}, {8'b0100, 1'b0});

    // Exhaustive N=4.
    for (int av = 0; av < 16; av++)
      for (int bv = 0; bv < 16; bv++)
        for (int iv = 0; iv < 2; iv++) begin
          op(0, 8'(av), 8'(bv), 1'(iv), rd, rb, lat, bc);
          e = model(4, av, bv, iv);
          chk($sformatf("n4_%0d_%0d_%0d", av, bv, iv),
              {rd, rb, 8'(lat)}, {e[7:0], e[8], 8'd4});
        end

    // Exhaustive N=1.
    for (int av = 0; av < 2; av++)
      for (int bv = 0; bv < 2; bv++)
        for (int iv = 0; iv < 2; iv++) begin
          op(1, 8'(av), 8'(bv), 1'(iv), rd, rb, lat, bc);
          e = model(1, av, bv, iv);
          chk($sformatf("n1_%0d_%0d_%0d", av, bv, iv),
              {rd, rb, 8'(lat), 8'(bc)}, {e[7:0], e[8], 8'd1, 8'd1});
        end

    // Random N=8 plus corners.
    for (int i = 0; i < 1004; i++) begin
      int av;
      int bv;
      int iv;
      av = int'($urandom_range(255));
      bv = int'($urandom_range(255));
      iv = int'($urandom_range(1));
      if (i == 1000) begin av = 0;   bv = 255; iv = 1; end
      if (i == 1001) begin av = 255; bv = 0;   iv = 0; end
      if (i == 1002) begin av = 0;   bv = 0;   iv = 1; end
      if (i == 1003) begin av = 128; bv = 127; iv = 1; end
      op(2, 8'(av), 8'(bv), 1'(iv), rd, rb, lat, bc);
      e = model(8, av, bv, iv);
      chk($sformatf("n8_%0d_%0d_%0d", av, bv, iv),
          {rd, rb, 8'(lat)}, {e[7:0], e[8], 8'd8});
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
